// File: rtl/uart_dbg_pkg.sv
// Shared types and helpers for the debugger UART blocks.
package uart_dbg_pkg;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } byte_state_e;

  localparam int WORD_BYTES = 4;

  // Integer-truncated clocks per serial bit; clk_rate is in MHz.
  function automatic int clks_per_bit(input int clk_rate, input int baud);
    return (clk_rate * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, start/data/stop FSM, bit counter.
// After a framing error, start detection stays blocked until the line reads high.
module uart_rx_byte
  import uart_dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       srx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       rx_idle
);

  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);

  byte_state_e      state_q;
  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       data_q;
  logic             block_q;
  logic             byte_valid_q;
  logic             frame_err_q;
  logic [7:0]       rx_byte_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= B_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      data_q       <= '0;
      block_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_byte_q    <= '0;
    end else begin
      sync1_q      <= srx;
      sync2_q      <= sync1_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        B_IDLE: begin
          if (block_q) begin
            if (sync2_q) block_q <= 1'b0;
          end else if (!sync2_q) begin
            state_q <= B_START;
            cnt_q   <= '0;
          end
        end
        B_START: begin
          // Mid-start resample rejects glitches shorter than half a bit.
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= sync2_q ? B_IDLE : B_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        B_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            data_q    <= {sync2_q, data_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= B_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        B_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= B_IDLE;
            if (sync2_q) begin
              byte_valid_q <= 1'b1;
              rx_byte_q    <= data_q;
            end else begin
              frame_err_q <= 1'b1;
              block_q     <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= B_IDLE;
      endcase
    end
  end

  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign rx_byte    = rx_byte_q;
  assign rx_idle    = (state_q == B_IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// Assembles four received bytes (MSB first) into a 32-bit word with valid/err strobes.
// Optional inter-byte timeout: define UART_RX_WORD_TIMEOUT_EN.
module uart_rx_word
  import uart_dbg_pkg::*;
#(
  parameter int CLK_RATE     = -1,
  parameter int BAUD         = -1,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        srx,
  output logic [31:0] rx_word,
  output logic        valid,
  output logic        err,
  output logic        busy
);

  localparam int CPB = clks_per_bit(CLK_RATE, BAUD);

  generate
    if (CLK_RATE <= 0 || BAUD <= 0 || CPB < 4 || TIMEOUT_BITS < 1) begin : g_bad_cfg
      $error("uart_rx_word: CLK_RATE and BAUD must be overridden (>=4 clocks per bit)");
    end
  endgenerate

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic       rx_idle;
  logic       timeout;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .srx       (srx),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err),
    .rx_idle   (rx_idle)
  );

  logic [1:0]  count_q,   count_d;
  logic [23:0] shreg_q,   shreg_d;
  logic [31:0] rx_word_q, rx_word_d;
  logic        valid_q,   valid_d;
  logic        err_q,     err_d;

`ifdef UART_RX_WORD_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts elapsed cycles since the last byte event, the event cycle itself
  // counting as one; a byte event always takes priority over expiry.
  always_comb begin
    to_cnt_d = to_cnt_q;
    timeout  = 1'b0;
    if (byte_valid || frame_err) begin
      to_cnt_d = TO_W'(1);
    end else if (count_q != 2'd0 && rx_idle) begin
      if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
        timeout  = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else if (count_q == 2'd0) begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    count_d   = count_q;
    shreg_d   = shreg_q;
    rx_word_d = rx_word_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (byte_valid) begin
      if (count_q == 2'(WORD_BYTES - 1)) begin
        rx_word_d = {shreg_q, rx_byte};
        valid_d   = 1'b1;
        count_d   = 2'd0;
      end else begin
        shreg_d = {shreg_q[15:0], rx_byte};
        count_d = count_q + 2'd1;
      end
    end else if (frame_err || timeout) begin
      count_d = 2'd0;
      shreg_d = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      shreg_q   <= '0;
      rx_word_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      rx_word_q <= rx_word_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign rx_word = rx_word_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign busy    = !rx_idle || (count_q != 2'd0);

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word at 10 clocks per bit: vector table, corner sequences,
// and random byte streams checked against an abstract word/err event model.
module tb_uart_rx_word;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        srx = 1'b1;
  logic [31:0] rx_word;
  logic        valid;
  logic        err;
  logic        busy;

  uart_rx_word #(
    .CLK_RATE    (10),
    .BAUD        (1_000_000),
    .TIMEOUT_BITS(40)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .srx    (srx),
    .rx_word(rx_word),
    .valid  (valid),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_valid  = 0;
  int          n_err    = 0;
  int unsigned last_valid_cyc = 0;
  logic [31:0] last_word = '0;
  logic [32:0] act_q[$];
  logic [32:0] exp_q[$];
  int unsigned err_cyc_q[$];
  bit          busy_hist[65536];
  int unsigned last_start = 0;

  // Monitor: one line per observed strobe, away from the active edge.
  always @(negedge clk) begin
    busy_hist[cyc[15:0]] = busy;
    if (valid === 1'b1) begin
      n_valid++;
      last_word      = rx_word;
      last_valid_cyc = cyc;
      act_q.push_back({1'b0, rx_word});
      $display("cyc %0d: valid word=%h", cyc, rx_word);
    end
    if (err === 1'b1) begin
      n_err++;
      err_cyc_q.push_back(cyc);
      act_q.push_back({1'b1, 32'h0});
      $display("cyc %0d: err", cyc);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame starting right now, then gap_bits of idle line.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap_bits);
    last_start = cyc;
    srx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_cycles(CPB);
      srx = b[i];
    end
    wait_cycles(CPB);
    srx = stop_bit;
    wait_cycles(CPB);
    srx = 1'b1;
    wait_cycles(gap_bits * CPB);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_bits);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 1'b1, gap_bits);
  endtask

  task automatic compare_events(input string name);
    check({name, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s_ev%0d", name, i), 64'(act_q[i]), 64'(exp_q[i]));
  endtask

  typedef struct {
    logic [31:0] word;
    int          gap;
    int          bad_prefix;  // send this many leading bytes, the last with a bad stop bit
    int          exp_valid;
    int          exp_err;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, e0;
    int unsigned s22;
    logic [7:0] acc[$];

    vecs[0] = '{32'hDEADBEEF, 2, 0, 1, 0, 32'hDEADBEEF};
    vecs[1] = '{32'h01234567, 0, 0, 1, 0, 32'h01234567};
    vecs[2] = '{32'h89ABCDEF, 0, 0, 1, 0, 32'h89ABCDEF};
    vecs[3] = '{32'hCAFEF00D, 2, 2, 1, 1, 32'hCAFEF00D};
    vecs[4] = '{32'h00000000, 1, 0, 1, 0, 32'h00000000};
    vecs[5] = '{32'hFFFFFFFF, 3, 1, 1, 1, 32'hFFFFFFFF};
    vecs[6] = '{32'h5A3C0FF0, 0, 4, 1, 1, 32'h5A3C0FF0};

    // Reset state
    wait_cycles(3);
    check("rst_rx_word", 64'(rx_word), 64'h0);
    check("rst_valid",   64'(valid),   64'h0);
    check("rst_err",     64'(err),     64'h0);
    check("rst_busy",    64'(busy),    64'h0);
    rst = 1'b0;
    wait_cycles(20);

    // Vector table
    foreach (vecs[i]) begin
      v0 = n_valid;
      e0 = n_err;
      for (int k = 0; k < vecs[i].bad_prefix; k++) begin
        if (k == vecs[i].bad_prefix - 1) send_byte(vecs[i].word[31-8*k -: 8], 1'b0, 2);
        else                             send_byte(vecs[i].word[31-8*k -: 8], 1'b1, vecs[i].gap);
      end
      send_word(vecs[i].word, vecs[i].gap);
      wait_cycles(5);
      check($sformatf("vec%0d_valid_cnt", i), 64'(n_valid - v0), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_err_cnt", i),   64'(n_err - e0),   64'(vecs[i].exp_err));
      check($sformatf("vec%0d_word", i),      64'(last_word),    64'(vecs[i].exp_word));
      check($sformatf("vec%0d_valid_lat", i), 64'(last_valid_cyc - last_start), 64'd99);
      check($sformatf("vec%0d_busy_mid", i),  64'(busy_hist[16'(last_start - 5)]),  64'd1);
      check($sformatf("vec%0d_busy_stop", i), 64'(busy_hist[16'(last_start + 98)]), 64'd1);
      check($sformatf("vec%0d_busy_done", i), 64'(busy_hist[16'(last_start + 99)]), 64'd0);
      wait_cycles(5);
    end

    // Short low glitch on an idle line
    v0 = n_valid;
    e0 = n_err;
    srx = 1'b0;
    wait_cycles(3);
    srx = 1'b1;
    wait_cycles(40);
    check("glitch_valid", 64'(n_valid - v0), 64'd0);
    check("glitch_err",   64'(n_err - e0),   64'd0);
    check("glitch_busy",  64'(busy),         64'd0);

    // Long inter-byte gaps
    act_q.delete();
    exp_q.delete();
    err_cyc_q.delete();
    send_byte(8'h11, 1'b1, 2);
    send_byte(8'h22, 1'b1, 50);
    s22 = last_start;
    send_byte(8'h33, 1'b1, 2);
    send_byte(8'h44, 1'b1, 50);
    send_word(32'hA5A5A5A5, 2);
    wait_cycles(5);
`ifdef UART_RX_WORD_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    compare_events("timeout");
    check("timeout_err_seen", 64'(err_cyc_q.size() > 0), 64'd1);
    if (err_cyc_q.size() > 0) check("timeout_err_cycle", 64'(err_cyc_q[0] - s22), 64'd498);
`else
    exp_q.push_back({1'b0, 32'h11223344});
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    compare_events("no_timeout");
    check("no_timeout_err_none", 64'(err_cyc_q.size()), 64'd0);
`endif

    // Random byte stream against the event model
    act_q.delete();
    exp_q.delete();
    acc.delete();
    for (int n = 0; n < 48; n++) begin
      logic [7:0] b;
      bit bad;
      int gap;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      if (bad)                            gap = $urandom_range(2, 3);
      else if ($urandom_range(0, 9) == 0) gap = 45;
      else                                gap = $urandom_range(0, 3);
      send_byte(b, !bad, gap);
      if (bad) begin
        exp_q.push_back({1'b1, 32'h0});
        acc.delete();
      end else begin
        acc.push_back(b);
        if (acc.size() == 4) begin
          exp_q.push_back({1'b0, acc[0], acc[1], acc[2], acc[3]});
          acc.delete();
        end
      end
`ifdef UART_RX_WORD_TIMEOUT_EN
      if (gap >= 45 && acc.size() != 0) begin
        exp_q.push_back({1'b1, 32'h0});
        acc.delete();
      end
`endif
    end
`ifdef UART_RX_WORD_TIMEOUT_EN
    if (acc.size() != 0) exp_q.push_back({1'b1, 32'h0});
`endif
    wait_cycles(60 * CPB);
    compare_events("rand");

    // Reset during the third byte of a word
    send_byte(8'h12, 1'b1, 0);
    send_byte(8'h34, 1'b1, 0);
    srx = 1'b0;
    wait_cycles(3 * CPB);
    rst = 1'b1;
    srx = 1'b1;
    v0 = n_valid;
    e0 = n_err;
    wait_cycles(1);
    check("mid_rst_rx_word", 64'(rx_word), 64'h0);
    check("mid_rst_valid",   64'(valid),   64'h0);
    check("mid_rst_err",     64'(err),     64'h0);
    check("mid_rst_busy",    64'(busy),    64'h0);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(10);
    send_word(32'h0BADF00D, 2);
    wait_cycles(5);
    check("post_rst_valid_cnt", 64'(n_valid - v0), 64'd1);
    check("post_rst_err_cnt",   64'(n_err - e0),   64'd0);
    check("post_rst_word",      64'(last_word),    64'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Receive-side counterpart of the debugger's word transmitter. It deserialises a raw 8N1 UART stream, assembles four consecutive bytes, most significant byte first, into a 32-bit word, and presents the word with a one-cycle strobe. It sits between the host serial input pin and the debugger command decoder. It reports framing errors and, optionally, inter-byte timeouts, so the decoder can resynchronise.

## Interface
- `CLK_RATE`, default -1: clk frequency in MHz; must be overridden.
- `BAUD`, default -1: serial rate in bits/s; must be overridden.
- `TIMEOUT_BITS`, default 40: inter-byte timeout in bit periods; used only with `UART_RX_WORD_TIMEOUT_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `srx`  in  1  asynchronous serial input; idles high.
- `rx_word`  out  32  last complete word; held until the next completion.
- `valid`  out  1  one-shot; high for one cycle when `rx_word` updates.
- `err`  out  1  one-shot; partial word discarded because of a framing error or timeout.
- `busy`  out  1  level; high while a byte is in flight or a partial word is held.

## Operation
- Bit period: `CLKS_PER_BIT = CLK_RATE*1_000_000/BAUD`, integer-truncated. `HALF = (CLKS_PER_BIT-1)/2`.
- `srx` passes through a 2-flop synchroniser. Both flops reset to 1.
- The byte receiver FSM has four states: B_IDLE, B_START, B_DATA, B_STOP.
  - B_IDLE: a synchronised low moves to B_START and clears the clock counter.
  - B_START: at count HALF, resample. Low moves to B_DATA; high is a glitch and returns to B_IDLE.
  - B_DATA: sample every CLKS_PER_BIT clocks, LSB first. After 8 bits, move to B_STOP.
  - B_STOP: sample after CLKS_PER_BIT clocks.
    - High: pulse `byte_valid` with the byte.
    - Low: pulse `frame_err`, then block new start detection until the line is sampled high.
    - Either way, return to B_IDLE.
- Word layer:
  - Holds a 2-bit byte count and a 24-bit shift register.
  - On `byte_valid` with count < 3: shift in the byte, count +1.
  - On `byte_valid` with count == 3: `rx_word <= {shreg, byte}`, pulse `valid`, count <= 0.
  - `frame_err`: count <= 0, shreg <= 0, pulse `err`. `rx_word` is unchanged.
- `busy = (byte FSM != B_IDLE) | (count != 0)`.
- There is no back-pressure. The consumer must capture `rx_word` before the next word completes, which takes at least 40 bit periods.

## Timing
- Reset values: `rx_word`=0, `valid`=0, `err`=0, `busy`=0. FSM=B_IDLE, count=0, shreg=0.
- `byte_valid` and `frame_err` are registered and assert the cycle after the stop-bit sample.
- `valid` and `err` assert the cycle after `byte_valid` / `frame_err`. `rx_word` changes in the same cycle `valid` rises.
- Back-to-back frames are accepted. A start edge in the cycle after the stop sample is detected.
- Simultaneous timeout expiry and `byte_valid` in the same cycle: the byte wins and the timeout counter reloads.
- Reset mid-byte or mid-word discards everything. No `valid` or `err` is produced.

## Configuration
- Macro: `UART_RX_WORD_TIMEOUT_EN`.
- Defined:
  - A counter runs while count != 0 and the byte FSM is in B_IDLE. It clears on every `byte_valid` or `frame_err`.
  - On reaching `TIMEOUT_BITS*CLKS_PER_BIT`: count <= 0, shreg <= 0, pulse `err` next cycle.
- Not defined:
  - No counter. A partial word is held indefinitely.
  - `err` comes from framing errors only.

## Structure
- Shared package `uart_dbg_pkg`:
  - byte-FSM state enum;
  - `function clks_per_bit(clk_rate, baud)`;
  - `localparam WORD_BYTES = 4`.
- Sub-module `uart_rx_byte`:
  - contains the synchroniser, byte FSM and bit counter;
  - ports clk, rst, srx, `byte_valid`, `rx_byte[7:0]`, `frame_err`, `rx_idle`.
- `uart_rx_word` contains the word-assembly and timeout logic only.

## Test plan
All scenarios use `CLK_RATE`=10 and `BAUD`=1_000_000, giving `CLKS_PER_BIT`=10.
- Frames 0xDE, 0xAD, 0xBE, 0xEF with 2-bit gaps -> exactly one `valid`, `rx_word`=0xDEADBEEF, `err` never high.
- Words 0x01234567 then 0x89ABCDEF, zero idle between frames -> two `valid` pulses with the correct words; `busy` low only after the final stop bit.
- Second byte of 0xCAFEF00D sent with stop bit 0, then the full 0xCAFEF00D -> one `err` and no `valid`; then `valid` with 0xCAFEF00D.
- 3-cycle low glitch on an idle line -> no `valid` or `err`; count remains 0.
- Bytes 0x11, 0x22, then 50 bit periods idle, then 0x33, 0x44:
  - macro defined: `err` 400 cycles after the 0x22 `byte_valid`, no `valid`; a following 0xA5A5A5A5 is received correctly.
  - macro undefined: `valid` with 0x11223344.
- `rst` pulsed during byte 3 of a word, then 0x0BADF00D -> outputs 0 during reset, no spurious strobes, then `valid` with 0x0BADF00D.
